clk_div_multi: RTL and testbench

- Parametrised successor to the single-channel fixed clk_div: N_CH independent divider channels from one CLK_100MHz domain.
- Each channel's divisor is runtime-programmable, with a glitch-free update at the period boundary.
- Each channel gives a one-cycle tick (clock-enable) and a near-50 % square wave (LED blink / slow strobe).
- Channels can be individually enabled and phase-aligned with a common sync clear.
- Sits beside the CPU GPIO; feeds LED, 7-seg scan and debounce enables.

---
 rtl/clk_div_multi.sv | 101 ++++++++++
 tb/tb_clk_div_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel tick (clock-enable) and
// near-50% square wave, runtime divisor updates taking effect on period boundaries.
module clk_div_multi #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CH_W  = 2,
   parameter int unsigned CNT_W = 27,
   parameter logic [N_CH*CNT_W-1:0] DIV_INIT =
      {27'd1000, 27'd100_000, 27'd10_000_000, 27'd100_000_000}
) (
   input  logic              CLK_100MHz,
   input  logic              n_rst,
   input  logic [N_CH-1:0]   en,
   input  logic              sync_clr,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   clk_out,
   output logic [N_CH-1:0]   div_pend
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      localparam logic [CNT_W-1:0] DIV_RST = DIV_INIT[i*CNT_W +: CNT_W];

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] act_q, act_d;
      logic [CNT_W-1:0] pnd_q, pnd_d;
      logic             tick_q, tick_d;
      logic             clk_q, clk_d;
      logic             pend_q, pend_d;

      logic [CNT_W-1:0] d_eff;
      logic [CNT_W-1:0] half;
      logic [CNT_W-1:0] cnt_nxt;
      logic             wrap;
      logic             wr_hit;

      // A stored divisor of zero behaves as divide-by-one.
      assign d_eff   = (act_q == '0) ? CNT_W'(1) : act_q;
      assign half    = d_eff >> 1;
      assign wrap    = (cnt_q == d_eff - CNT_W'(1));
      assign cnt_nxt = wrap ? '0 : cnt_q + CNT_W'(1);
      assign wr_hit  = wr_en && (wr_ch == CH_W'(i));

      // Next-state: cleared/disabled channels take divisors at once,
      // running channels only switch divisor on the wrap edge.
      always_comb begin
         cnt_d  = cnt_q;
         act_d  = act_q;
         pnd_d  = pnd_q;
         pend_d = pend_q;
         tick_d = 1'b0;
         clk_d  = 1'b0;
         if (sync_clr || !en[i]) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (wr_hit) begin
               act_d = wr_div;
               pnd_d = wr_div;
            end else begin
               act_d = pnd_q;
            end
         end else begin
            cnt_d  = cnt_nxt;
            tick_d = wrap;
            clk_d  = (cnt_nxt >= half);
            if (wrap) begin
               act_d  = pnd_q;
               pend_d = 1'b0;
            end
            if (wr_hit) begin
               pnd_d  = wr_div;
               pend_d = 1'b1;
            end
         end
      end

      always_ff @(posedge CLK_100MHz or negedge n_rst) begin
         if (!n_rst) begin
            cnt_q  <= '0;
            act_q  <= DIV_RST;
            pnd_q  <= DIV_RST;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
            pend_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pnd_q  <= pnd_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
            pend_q <= pend_d;
         end
      end

      assign tick[i]     = tick_q;
      assign clk_out[i]  = clk_q;
      assign div_pend[i] = pend_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi with hand-derived expectations.
module tb_clk_div_multi;
   localparam int unsigned N_CH  = 4;
   localparam int unsigned CH_W  = 3;
   localparam int unsigned CNT_W = 27;

   logic             clk = 1'b0;
   logic             n_rst;
   logic [N_CH-1:0]  en;
   logic             sync_clr;
   logic             wr_en;
   logic [CH_W-1:0]  wr_ch;
   logic [CNT_W-1:0] wr_div;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  clk_out;
   logic [N_CH-1:0]  div_pend;

   int checks   = 0;
   int failures = 0;
   int k        = 0;

   always #5 clk = ~clk;

   clk_div_multi #(
      .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W),
      .DIV_INIT({27'd0, 27'd1, 27'd5, 27'd4})
   ) dut (
      .CLK_100MHz(clk), .n_rst(n_rst), .en(en), .sync_clr(sync_clr),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
      .tick(tick), .clk_out(clk_out), .div_pend(div_pend)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=0x%0h expected=0x%0h", tag, k, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic set_wr(input int ch, input int v);
      wr_en  = 1'b1;
      wr_ch  = CH_W'(ch);
      wr_div = CNT_W'(v);
   endtask

   // Expected outputs after edge e from reset release with DIV_INIT {0,1,5,4}.
   function automatic logic [3:0] p1_tick(input int e);
      return {2'b11, (e % 5 == 0), (e % 4 == 0)};
   endfunction
   function automatic logic [3:0] p1_clk(input int e);
      return {2'b11, ((e % 5) >= 2), ((e % 4) >= 2)};
   endfunction

   bit t1_a [13] = '{0,0,1,0,0,1,0,0,1,0,0,0,1};
   bit c1_a [13] = '{1,1,0,1,1,0,1,1,0,0,1,1,0};
   bit p1_a [13] = '{1,1,0,0,0,1,1,1,0,0,0,0,0};
   bit t1_b [12] = '{0,0,0,0,0,0,0,0,0,0,1,0};
   bit c1_b [12] = '{0,1,0,0,0,0,1,1,1,1,0,0};
   bit p1_b [12] = '{0,1,0,0,0,0,0,0,0,0,0,0};

   initial begin
      #200000;
      $display("FAIL watchdog expired at edge %0d", k);
      $fatal(1, "watchdog");
   end

   initial begin
      logic e_t, e_c, e_p, t0, t1, c0, c1;
      n_rst = 1'b0; en = '0; sync_clr = 1'b0;
      wr_en = 1'b0; wr_ch = '0; wr_div = '0;

      // Reset state
      #3;
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_clk", 32'(clk_out), 32'd0);
      chk("rst_pend", 32'(div_pend), 32'd0);
      @(posedge clk); #1;
      n_rst = 1'b1; en = 4'hF; k = 0;

      // Initial divisors, including d=1 and stored 0
      repeat (12) begin
         step();
         chk("p1_tick", 32'(tick), 32'(p1_tick(k)));
         chk("p1_clk", 32'(clk_out), 32'(p1_clk(k)));
         chk("p1_pend", 32'(div_pend), 32'd0);
      end

      // ch0 4 -> 8 written at cnt=1, switch on the wrap at edge 16
      step();
      set_wr(0, 8);
      repeat (19) begin
         step();
         wr_en = 1'b0;
         e_t = (k == 16 || k == 24 || k == 32);
         e_c = (k <= 16) ? ((k % 4) >= 2) : (((k - 16) % 8) >= 4);
         e_p = (k == 14 || k == 15);
         chk("p2_tick0", 32'(tick[0]), 32'(e_t));
         chk("p2_clk0", 32'(clk_out[0]), 32'(e_c));
         chk("p2_pend0", 32'(div_pend[0]), 32'(e_p));
      end

      // ch1: 6 then 3 (last wins), out-of-range write, write on the wrap edge
      repeat (13) begin
         wr_en = 1'b0;
         case (k + 1)
            33: set_wr(1, 6);
            34: set_wr(1, 3);
            35: set_wr(5, 9);
            38: set_wr(1, 4);
            default: ;
         endcase
         step();
         chk("p3_tick1", 32'(tick[1]), 32'(t1_a[k-33]));
         chk("p3_clk1", 32'(clk_out[1]), 32'(c1_a[k-33]));
         chk("p3_pend", 32'(div_pend), 32'(p1_a[k-33]) << 1);
      end
      wr_en = 1'b0;

      // ch1 disabled mid-period with pending 7, then re-enabled
      repeat (12) begin
         wr_en = 1'b0;
         case (k + 1)
            47: set_wr(1, 7);
            48: en = 4'b1101;
            50: en = 4'hF;
            default: ;
         endcase
         step();
         chk("p4_tick1", 32'(tick[1]), 32'(t1_b[k-46]));
         chk("p4_clk1", 32'(clk_out[1]), 32'(c1_b[k-46]));
         chk("p4_pend1", 32'(div_pend[1]), 32'(p1_b[k-46]));
      end
      wr_en = 1'b0;

      // Align ch0/ch1 at d=4 via sync_clr
      set_wr(0, 4);
      step();
      wr_en = 1'b0;
      chk("p5_pend0", 32'(div_pend), 32'd1);
      sync_clr = 1'b1;
      set_wr(1, 4);
      step();
      sync_clr = 1'b0; wr_en = 1'b0;
      chk("p5_clr_tick", 32'(tick), 32'd0);
      chk("p5_clr_clk", 32'(clk_out), 32'd0);
      chk("p5_clr_pend", 32'(div_pend), 32'd0);
      repeat (8) begin
         step();
         e_t = ((k - 59) % 4 == 0);
         e_c = (((k - 59) % 4) >= 2);
         chk("p5_tick", 32'(tick), 32'({2'b11, e_t, e_t}));
         chk("p5_clk", 32'(clk_out), 32'({2'b11, e_c, e_c}));
      end

      // sync_clr with simultaneous write of 2 to ch0
      sync_clr = 1'b1;
      set_wr(0, 2);
      step();
      sync_clr = 1'b0; wr_en = 1'b0;
      chk("p5b_clr_tick", 32'(tick), 32'd0);
      chk("p5b_clr_clk", 32'(clk_out), 32'd0);
      chk("p5b_clr_pend", 32'(div_pend), 32'd0);
      repeat (8) begin
         step();
         t0 = ((k - 68) % 2 == 0);
         c0 = ((k - 68) % 2 == 1);
         t1 = ((k - 68) % 4 == 0);
         c1 = (((k - 68) % 4) >= 2);
         chk("p5b_tick", 32'(tick), 32'({2'b11, t1, t0}));
         chk("p5b_clk", 32'(clk_out), 32'({2'b11, c1, c0}));
         chk("p5b_pend", 32'(div_pend), 32'd0);
      end

      // Asynchronous reset mid-count
      step();
      @(posedge clk); #3;
      n_rst = 1'b0;
      #1;
      chk("p6_async_tick", 32'(tick), 32'd0);
      chk("p6_async_clk", 32'(clk_out), 32'd0);
      chk("p6_async_pend", 32'(div_pend), 32'd0);
      step();
      chk("p6_held_tick", 32'(tick), 32'd0);
      n_rst = 1'b1; k = 0;
      repeat (5) begin
         step();
         chk("p6_tick", 32'(tick), 32'(p1_tick(k)));
         chk("p6_clk", 32'(clk_out), 32'(p1_clk(k)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
